// File: rtl/reg_ctrl_pkg.sv
// Shared constants for the register-bank write path.
// Port indices double as the round-robin pointer encoding.
package reg_ctrl_pkg;

    localparam int NREG = 8;
    localparam int DW   = 8;
    localparam int AW   = 3;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam logic [7:0] CONFLICT_MAX = 8'd255;

    function automatic logic [NREG-1:0] onehot(
        input logic [AW-1:0] a
    );
        logic [NREG-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter, purely combinational.
// The caller owns the pointer register and feeds it back.
module rr_arb2
    import reg_ctrl_pkg::*;
(
    input  logic [1:0] elig,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       next_last
);

    always_comb begin
        grant     = '0;
        next_last = last_grant;
        unique case (elig)
            2'b01: begin
                grant[PORT_A] = 1'b1;
                next_last     = PORT_A;
            end
            2'b10: begin
                grant[PORT_B] = 1'b1;
                next_last     = PORT_B;
            end
            2'b11: begin
                // contention goes to whoever did not win last time
                if (last_grant == PORT_B) begin
                    grant[PORT_A] = 1'b1;
                    next_last     = PORT_A;
                end else begin
                    grant[PORT_B] = 1'b1;
                    next_last     = PORT_B;
                end
            end
            default: begin
                grant     = '0;
                next_last = last_grant;
            end
        endcase
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-bank write port between ALU writeback (A)
// and the load/immediate path (B) with a registered req/gnt handshake.
module reg_write_arbiter
    import reg_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            a_req,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_data,
    output logic            a_gnt,
    input  logic            b_req,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_data,
    output logic            b_gnt,
    output logic [NREG-1:0] re_vec,
    output logic [DW-1:0]   wdata,
    output logic            last_grant,
    output logic [7:0]      conflict_cnt
);

    logic       a_elig;
    logic       b_elig;
    logic [1:0] elig;
    logic [1:0] grant;
    logic       next_last;

    // a port whose grant is on the bus this cycle cannot win again
    assign a_elig = a_req & ~a_gnt & ~hold;
    assign b_elig = b_req & ~b_gnt & ~hold;

    assign elig[PORT_A] = a_elig;
    assign elig[PORT_B] = b_elig;

    rr_arb2 u_arb (
        .elig       (elig),
        .last_grant (last_grant),
        .grant      (grant),
        .next_last  (next_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_gnt        <= 1'b0;
            b_gnt        <= 1'b0;
            re_vec       <= '0;
            wdata        <= '0;
            last_grant   <= PORT_B;
            conflict_cnt <= '0;
        end else begin
            a_gnt      <= grant[PORT_A];
            b_gnt      <= grant[PORT_B];
            last_grant <= next_last;
            unique case (1'b1)
                grant[PORT_A]: begin
                    re_vec <= onehot(a_addr);
                    wdata  <= a_data;
                end
                grant[PORT_B]: begin
                    re_vec <= onehot(b_addr);
                    wdata  <= b_data;
                end
                default: begin
                    re_vec <= '0;
                end
            endcase
            if (a_elig && b_elig && conflict_cnt != CONFLICT_MAX) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomised and directed bench for reg_write_arbiter.
// A cycle-level reference model predicts every output one cycle ahead.
module tb_reg_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold;
    logic       a_req;
    logic [2:0] a_addr;
    logic [7:0] a_data;
    logic       a_gnt;
    logic       b_req;
    logic [2:0] b_addr;
    logic [7:0] b_data;
    logic       b_gnt;
    logic [7:0] re_vec;
    logic [7:0] wdata;
    logic       last_grant;
    logic [7:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state (value visible in the current cycle)
    bit       m_a_gnt;
    bit       m_b_gnt;
    bit [7:0] m_re;
    bit [7:0] m_wdata;
    int       m_last;
    int       m_cnt;
    bit [7:0] m_bank [8];
    bit [7:0] d_bank [8];

    bit a_rel;
    bit b_rel;

    reg_write_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .a_req        (a_req),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_gnt        (a_gnt),
        .b_req        (b_req),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_gnt        (b_gnt),
        .re_vec       (re_vec),
        .wdata        (wdata),
        .last_grant   (last_grant),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one cycle: predict from the inputs now applied, then compare
    task automatic tick();
        bit ae;
        bit be;
        int win;
        for (int i = 0; i < 8; i++) begin
            if (m_re[i]) m_bank[i] = m_wdata;
        end
        if (rst) begin
            m_a_gnt = 0;
            m_b_gnt = 0;
            m_re    = 0;
            m_wdata = 0;
            m_last  = 1;
            m_cnt   = 0;
        end else begin
            ae  = a_req && !m_a_gnt && !hold;
            be  = b_req && !m_b_gnt && !hold;
            win = -1;
            if (ae && be) win = (m_last == 1) ? 0 : 1;
            else if (ae) win = 0;
            else if (be) win = 1;
            if (ae && be && m_cnt < 255) m_cnt++;
            m_a_gnt = (win == 0);
            m_b_gnt = (win == 1);
            m_re    = 0;
            if (win == 0) begin
                m_re[a_addr] = 1'b1;
                m_wdata      = a_data;
            end else if (win == 1) begin
                m_re[b_addr] = 1'b1;
                m_wdata      = b_data;
            end
            if (win >= 0) m_last = win;
        end
        @(negedge clk);
        check("a_gnt", a_gnt, m_a_gnt);
        check("b_gnt", b_gnt, m_b_gnt);
        check("re_vec", re_vec, m_re);
        check("wdata", wdata, m_wdata);
        check("last_grant", last_grant, m_last);
        check("conflict_cnt", conflict_cnt, m_cnt);
        for (int i = 0; i < 8; i++) begin
            if (re_vec[i]) d_bank[i] = wdata;
        end
    endtask

    task automatic drive_random();
        hold = ($urandom_range(0, 7) == 0);
        if (m_a_gnt) a_rel = 1;
        else if (a_rel || !a_req) begin
            a_rel  = 0;
            a_req  = ($urandom_range(0, 3) != 0);
            a_addr = 3'($urandom);
            a_data = 8'($urandom);
        end
        if (m_b_gnt) b_rel = 1;
        else if (b_rel || !b_req) begin
            b_rel  = 0;
            b_req  = ($urandom_range(0, 3) != 0);
            b_addr = 3'($urandom);
            b_data = 8'($urandom);
        end
    endtask

    initial begin
        rst    = 1;
        hold   = 0;
        a_req  = 0;
        a_addr = 0;
        a_data = 0;
        b_req  = 0;
        b_addr = 0;
        b_data = 0;
        tick();
        check("rst_last", last_grant, 1);
        rst = 0;

        // single A write after reset
        a_req  = 1;
        a_addr = 3;
        a_data = 8'h5A;
        tick();
        check("t1_gnt", a_gnt, 1);
        check("t1_re", re_vec, 8'h08);
        check("t1_wd", wdata, 8'h5A);
        tick();
        check("t1_mask", a_gnt, 0);
        a_req = 0;
        tick();

        // same address, pointer at A: B first, A final
        a_req  = 1;
        a_addr = 5;
        a_data = 8'hAA;
        b_req  = 1;
        b_addr = 5;
        b_data = 8'hBB;
        tick();
        check("t3_bfirst", b_gnt, 1);
        tick();
        check("t3_asecond", a_gnt, 1);
        b_req = 0;
        tick();
        a_req = 0;
        tick();
        check("t3_bank5", d_bank[5], 8'hAA);

        // continuous contention from reset alternates every cycle
        rst = 1;
        tick();
        rst    = 0;
        a_req  = 1;
        a_addr = 1;
        a_data = 8'h11;
        b_req  = 1;
        b_addr = 2;
        b_data = 8'h22;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t2_agnt", a_gnt, (i % 2 == 0));
            check("t2_re", re_vec, (i % 2 == 0) ? 8'h02 : 8'h04);
        end
        check("t2_cnt", conflict_cnt, 1);
        a_req = 0;
        b_req = 0;
        tick();
        tick();

        // hold stalls a request without losing it
        hold   = 1;
        a_req  = 1;
        a_addr = 6;
        a_data = 8'h66;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_gnt", a_gnt, 0);
            check("t4_hold_re", re_vec, 0);
        end
        hold = 0;
        tick();
        check("t4_release", a_gnt, 1);
        tick();
        a_req = 0;
        tick();

        // saturation: hold every other cycle so both stay eligible
        a_req = 1;
        b_req = 1;
        for (int i = 0; i < 300; i++) begin
            hold = 0;
            tick();
            hold = 1;
            tick();
        end
        check("t5_sat", conflict_cnt, 8'd255);
        a_req = 0;
        b_req = 0;
        hold  = 0;
        tick();
        tick();

        // reset in the cycle a grant would be issued
        a_req  = 1;
        a_addr = 0;
        a_data = 8'h77;
        rst    = 1;
        tick();
        check("t6_gnt", a_gnt, 0);
        check("t6_re", re_vec, 0);
        check("t6_last", last_grant, 1);
        check("t6_cnt", conflict_cnt, 0);
        rst = 0;
        tick();
        check("t6_regrant", a_gnt, 1);
        check("t6_re1", re_vec, 8'h01);
        tick();
        a_req = 0;
        tick();

        // randomised traffic against the model
        a_rel = 0;
        b_rel = 0;
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            tick();
        end
        hold = 0;
        if (!m_a_gnt) a_req = 0;
        if (!m_b_gnt) b_req = 0;
        tick();
        a_req = 0;
        b_req = 0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bank%0d", i), d_bank[i], m_bank[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
